// File: rtl/board_controller_if.sv
// Move interface between a player front-end and board_controller.
//   new_game   : 1-cycle request to clear the board (tallies kept)
//   move_valid : move request present this cycle
//   move_pos   : square index 0..8
//   move_ready : controller can take a move this cycle
//   move_ok    : 1-cycle pulse, move accepted
//   move_bad   : 1-cycle pulse, move rejected
//   timeout    : 1-cycle pulse, turn forfeited
interface board_controller_if;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;
  logic       move_ok;
  logic       move_bad;
  logic       timeout;

  // Player side.
  modport master (
    output new_game, move_valid, move_pos,
    input  move_ready, move_ok, move_bad, timeout
  );

  // Controller side.
  modport slave (
    input  new_game, move_valid, move_pos,
    output move_ready, move_ok, move_bad, timeout
  );
endinterface

// File: rtl/board_controller.sv
// Tic-tac-toe game-state master. Holds the marked/owner board that feeds an external win checker,
// takes moves over board_controller_if, alternates turns, optionally forfeits slow turns, and
// keeps saturating X/O/draw tallies across games.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   mv                 : move interface (slave side)
//   gameOver/winner/draw : verdict from the win checker, combinational on marked/owner
//   marked, owner      : board state (owner is 0 on unmarked squares)
//   turn               : owner value of the player to move
//   game_done          : high while the game is over and the board frozen
//   score_x/o/draw     : saturating tallies of owner=1 wins, owner=0 wins, draws
module board_controller #(
  parameter logic        FIRST_PLAYER = 1'b0,
  parameter int unsigned MOVE_TIMEOUT = 0,
  parameter int unsigned TIMER_W      = 16,
  parameter int unsigned SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  board_controller_if.slave  mv,
  input  logic               gameOver,
  input  logic               winner,
  input  logic               draw,
  output logic [8:0]         marked,
  output logic [8:0]         owner,
  output logic               turn,
  output logic               game_done,
  output logic [SCORE_W-1:0] score_x,
  output logic [SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0] score_draw
);

  typedef enum logic [1:0] {StPlay, StCheck, StDone} state_e;

  localparam bit                 TimerEn      = (MOVE_TIMEOUT > 0);
  localparam int unsigned        TimerLastInt = TimerEn ? MOVE_TIMEOUT - 1 : 0;
  localparam logic [TIMER_W-1:0] TimerLast    = TIMER_W'(TimerLastInt);
  localparam logic [SCORE_W-1:0] ScoreMax     = '1;

  state_e               state_q, state_d;
  logic [8:0]           marked_q, marked_d;
  logic [8:0]           owner_q, owner_d;
  logic                 turn_q, turn_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 move_ok_q, move_ok_d;
  logic                 move_bad_q, move_bad_d;
  logic                 timeout_q, timeout_d;
  logic                 game_done_q, game_done_d;
  logic [SCORE_W-1:0]   score_x_q, score_x_d;
  logic [SCORE_W-1:0]   score_o_q, score_o_d;
  logic [SCORE_W-1:0]   score_draw_q, score_draw_d;

  logic [8:0] pos_oh;
  logic       handshake;
  logic       legal;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == ScoreMax) ? v : v + SCORE_W'(1);
  endfunction

  // Positions 9..15 shift out of the 9-bit vector and decode to all zeros.
  assign pos_oh    = 9'b1 << mv.move_pos;
  assign handshake = mv.move_valid && (state_q == StPlay);
  assign legal     = (mv.move_pos <= 4'd8) && ((marked_q & pos_oh) == 9'd0);

  always_comb begin
    state_d      = state_q;
    marked_d     = marked_q;
    owner_d      = owner_q;
    turn_d       = turn_q;
    timer_d      = timer_q;
    move_ok_d    = 1'b0;
    move_bad_d   = 1'b0;
    timeout_d    = 1'b0;
    game_done_d  = game_done_q;
    score_x_d    = score_x_q;
    score_o_d    = score_o_q;
    score_draw_d = score_draw_q;

    if (mv.new_game) begin
      // Wins over any move or verdict this cycle; tallies untouched.
      state_d     = StPlay;
      marked_d    = '0;
      owner_d     = '0;
      turn_d      = FIRST_PLAYER;
      timer_d     = '0;
      game_done_d = 1'b0;
    end else begin
      unique case (state_q)
        StPlay: begin
          if (handshake && legal) begin
            marked_d  = marked_q | pos_oh;
            owner_d   = owner_q | (pos_oh & {9{turn_q}});
            move_ok_d = 1'b1;
            timer_d   = '0;
            state_d   = StCheck;
          end else begin
            if (handshake) begin
              move_bad_d = 1'b1;
            end
            // A rejected move does not stop the clock on the current turn.
            if (TimerEn) begin
              if (timer_q == TimerLast) begin
                timeout_d = 1'b1;
                turn_d    = ~turn_q;
                timer_d   = '0;
              end else begin
                timer_d = timer_q + TIMER_W'(1);
              end
            end
          end
        end
        StCheck: begin
          // The checker is now looking at the board including the last move.
          if (gameOver) begin
            state_d     = StDone;
            game_done_d = 1'b1;
            if (draw) begin
              score_draw_d = sat_inc(score_draw_q);
            end else if (winner) begin
              score_x_d = sat_inc(score_x_q);
            end else begin
              score_o_d = sat_inc(score_o_q);
            end
          end else begin
            turn_d  = ~turn_q;
            state_d = StPlay;
          end
        end
        StDone: begin
          timer_d = '0;
        end
        default: begin
          state_d = StPlay;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StPlay;
      marked_q     <= '0;
      owner_q      <= '0;
      turn_q       <= FIRST_PLAYER;
      timer_q      <= '0;
      move_ok_q    <= 1'b0;
      move_bad_q   <= 1'b0;
      timeout_q    <= 1'b0;
      game_done_q  <= 1'b0;
      score_x_q    <= '0;
      score_o_q    <= '0;
      score_draw_q <= '0;
    end else begin
      state_q      <= state_d;
      marked_q     <= marked_d;
      owner_q      <= owner_d;
      turn_q       <= turn_d;
      timer_q      <= timer_d;
      move_ok_q    <= move_ok_d;
      move_bad_q   <= move_bad_d;
      timeout_q    <= timeout_d;
      game_done_q  <= game_done_d;
      score_x_q    <= score_x_d;
      score_o_q    <= score_o_d;
      score_draw_q <= score_draw_d;
    end
  end

  assign mv.move_ready = (state_q == StPlay);
  assign mv.move_ok    = move_ok_q;
  assign mv.move_bad   = move_bad_q;
  assign mv.timeout    = timeout_q;
  assign marked        = marked_q;
  assign owner         = owner_q;
  assign turn          = turn_q;
  assign game_done     = game_done_q;
  assign score_x       = score_x_q;
  assign score_o       = score_o_q;
  assign score_draw    = score_draw_q;

endmodule

// File: tb/tb_board_controller.sv
// Bench for board_controller: a win-checker stub closes the loop on the DUT board, a game-level
// model predicts every output each cycle, and scripted games pin known results before a random run.
module tb_board_controller;

  localparam logic        FirstPlayer = 1'b0;
  localparam int unsigned MoveTimeout = 7;
  localparam int unsigned TimerW      = 8;
  localparam int unsigned ScoreW      = 2;
  localparam int          ScoreMax    = (1 << ScoreW) - 1;

  // The eight winning lines of a 3x3 board, bit i = square i.
  localparam logic [8:0] LineMask [8] = '{
    9'b000000111, 9'b000111000, 9'b111000000,
    9'b001001001, 9'b010010010, 9'b100100100,
    9'b100010001, 9'b001010100
  };

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  board_controller_if mv ();

  logic              game_over, winner, draw;
  logic [8:0]        marked, owner;
  logic              turn, game_done;
  logic [ScoreW-1:0] score_x, score_o, score_draw;

  board_controller #(
    .FIRST_PLAYER (FirstPlayer),
    .MOVE_TIMEOUT (MoveTimeout),
    .TIMER_W      (TimerW),
    .SCORE_W      (ScoreW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mv         (mv),
    .gameOver   (game_over),
    .winner     (winner),
    .draw       (draw),
    .marked     (marked),
    .owner      (owner),
    .turn       (turn),
    .game_done  (game_done),
    .score_x    (score_x),
    .score_o    (score_o),
    .score_draw (score_draw)
  );

  // Returns {game_over, winner, draw} for a board.
  function automatic logic [2:0] verdict(input logic [8:0] mk, input logic [8:0] ow);
    logic win, who, dr;
    win = 1'b0;
    who = 1'b0;
    dr  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((mk & LineMask[i]) == LineMask[i]) begin
        if ((ow & LineMask[i]) == LineMask[i]) begin
          win = 1'b1;
          who = 1'b1;
        end else if ((ow & LineMask[i]) == 9'd0) begin
          win = 1'b1;
          who = 1'b0;
        end
      end
    end
    if (!win && mk == 9'h1ff) dr = 1'b1;
    return {win | dr, who, dr};
  endfunction

  // Win checker stub on the DUT board.
  always_comb {game_over, winner, draw} = verdict(marked, owner);

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- game-level model ----------------
  logic [8:0] m_marked, m_owner;
  logic       m_turn, m_pending, m_done, m_ok, m_bad, m_to;
  int         m_elapsed, m_sx, m_so, m_sd;
  logic [2:0] m_verdict;
  logic       m_legal;

  assign m_verdict = verdict(m_marked, m_owner);
  assign m_legal   = (mv.move_pos <= 4'd8) && !m_marked[mv.move_pos];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_marked <= '0; m_owner <= '0; m_turn <= FirstPlayer; m_elapsed <= 0;
      m_pending <= 1'b0; m_done <= 1'b0; m_ok <= 1'b0; m_bad <= 1'b0; m_to <= 1'b0;
      m_sx <= 0; m_so <= 0; m_sd <= 0;
    end else begin
      m_ok <= 1'b0; m_bad <= 1'b0; m_to <= 1'b0;
      if (mv.new_game) begin
        m_marked <= '0; m_owner <= '0; m_turn <= FirstPlayer; m_elapsed <= 0;
        m_pending <= 1'b0; m_done <= 1'b0;
      end else if (m_pending) begin
        m_pending <= 1'b0;
        if (m_verdict[2]) begin
          m_done <= 1'b1;
          if (m_verdict[0])      m_sd <= (m_sd < ScoreMax) ? m_sd + 1 : m_sd;
          else if (m_verdict[1]) m_sx <= (m_sx < ScoreMax) ? m_sx + 1 : m_sx;
          else                   m_so <= (m_so < ScoreMax) ? m_so + 1 : m_so;
        end else begin
          m_turn <= !m_turn;
        end
      end else if (!m_done) begin
        if (mv.move_valid && m_legal) begin
          m_marked[mv.move_pos] <= 1'b1;
          m_owner[mv.move_pos]  <= m_turn;
          m_ok <= 1'b1; m_elapsed <= 0; m_pending <= 1'b1;
        end else begin
          if (mv.move_valid) m_bad <= 1'b1;
          // Forfeit once MoveTimeout cycles of this turn have passed without a move.
          if (MoveTimeout > 0) begin
            if (m_elapsed + 1 == int'(MoveTimeout)) begin
              m_to <= 1'b1; m_turn <= !m_turn; m_elapsed <= 0;
            end else begin
              m_elapsed <= m_elapsed + 1;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && rst) begin
      check("move_ready", 32'(mv.move_ready), 32'(!m_pending && !m_done));
      check("marked",     32'(marked),        32'(m_marked));
      check("owner",      32'(owner),         32'(m_owner));
      check("turn",       32'(turn),          32'(m_turn));
      check("move_ok",    32'(mv.move_ok),    32'(m_ok));
      check("move_bad",   32'(mv.move_bad),   32'(m_bad));
      check("timeout",    32'(mv.timeout),    32'(m_to));
      check("game_done",  32'(game_done),     32'(m_done));
      check("score_x",    32'(score_x),       32'(m_sx));
      check("score_o",    32'(score_o),       32'(m_so));
      check("score_draw", 32'(score_draw),    32'(m_sd));
    end
  end

  // ---------------- stimulus helpers (all start and end just after a falling edge) ----------------
  task automatic new_game();
    mv.new_game = 1'b1;
    @(negedge clk);
    mv.new_game = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!mv.move_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(mv.move_ready), 32'd1);
  endtask

  task automatic drive_move(input int pos);
    mv.move_valid = 1'b1;
    mv.move_pos   = 4'(pos);
    @(negedge clk);
    mv.move_valid = 1'b0;
  endtask

  task automatic play_move(input int pos);
    wait_ready();
    drive_move(pos);
  endtask

  int t1_moves [5] = '{0, 3, 1, 4, 2};
  int t1_turns [5] = '{0, 1, 0, 1, 0};
  int t4_moves [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
  int t5_moves [6] = '{0, 3, 1, 4, 8, 5};

  initial begin
    int period;
    mv.new_game = 1'b0; mv.move_valid = 1'b0; mv.move_pos = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_marked", 32'(marked), 32'd0);
    check("rst_turn", 32'(turn), 32'(FirstPlayer));
    check("rst_ready", 32'(mv.move_ready), 32'd1);
    check("rst_done", 32'(game_done), 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;

    // 1: player 0 wins on the top row.
    for (int i = 0; i < 5; i++) begin
      wait_ready();
      check("t1_turn", 32'(turn), 32'(t1_turns[i]));
      drive_move(t1_moves[i]);
    end
    check("t1_ok", 32'(mv.move_ok), 32'd1);
    check("t1_not_yet_done", 32'(game_done), 32'd0);
    @(negedge clk);
    check("t1_done", 32'(game_done), 32'd1);
    check("t1_owner", 32'(owner), 32'h018);
    check("t1_marked", 32'(marked), 32'h01f);
    check("t1_score_o", 32'(score_o), 32'd1);
    drive_move(5);
    check("t1_frozen_bad", 32'(mv.move_bad), 32'd0);
    check("t1_frozen_marked", 32'(marked), 32'h01f);

    // 2: illegal squares.
    new_game();
    play_move(4);
    check("t2_marked", 32'(marked), 32'h010);
    wait_ready();
    check("t2_turn", 32'(turn), 32'd1);
    drive_move(9);
    check("t2_bad9", 32'(mv.move_bad), 32'd1);
    check("t2_ok9", 32'(mv.move_ok), 32'd0);
    check("t2_marked9", 32'(marked), 32'h010);
    drive_move(4);
    check("t2_bad4", 32'(mv.move_bad), 32'd1);
    check("t2_owner4", 32'(owner), 32'd0);
    check("t2_turn4", 32'(turn), 32'd1);

    // 3: turn timer.
    new_game();
    period = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mv.timeout) begin
        period = i;
        break;
      end
    end
    check("t3_period", 32'(period), 32'(MoveTimeout));
    check("t3_turn", 32'(turn), 32'd1);
    repeat (MoveTimeout - 1) @(negedge clk);
    drive_move(0);
    check("t3_last_ok", 32'(mv.move_ok), 32'd1);
    check("t3_last_to", 32'(mv.timeout), 32'd0);
    repeat (2) @(negedge clk);

    // 4: full board, no line.
    new_game();
    foreach (t4_moves[i]) play_move(t4_moves[i]);
    @(negedge clk);
    check("t4_draw", 32'(score_draw), 32'd1);
    check("t4_done", 32'(game_done), 32'd1);
    check("t4_owner", 32'(owner), 32'h072);
    check("t4_marked", 32'(marked), 32'h1ff);

    // 5: owner=1 wins four times; the tally saturates.
    for (int g = 0; g < 4; g++) begin
      new_game();
      foreach (t5_moves[i]) play_move(t5_moves[i]);
      repeat (2) @(negedge clk);
      check("t5_score_x", 32'(score_x), 32'((g + 1 < ScoreMax) ? g + 1 : ScoreMax));
    end
    check("t5_score_o", 32'(score_o), 32'd1);
    new_game();
    play_move(4);
    wait_ready();
    mv.new_game = 1'b1; mv.move_valid = 1'b1; mv.move_pos = 4'd2;
    @(negedge clk);
    mv.new_game = 1'b0; mv.move_valid = 1'b0;
    check("t5_ng_marked", 32'(marked), 32'd0);
    check("t5_ng_ok", 32'(mv.move_ok), 32'd0);
    check("t5_ng_bad", 32'(mv.move_bad), 32'd0);
    check("t5_ng_turn", 32'(turn), 32'(FirstPlayer));

    // 6: asynchronous reset in the verdict cycle.
    play_move(0);
    #2 rst = 1'b0;
    #1;
    check("t6_marked", 32'(marked), 32'd0);
    check("t6_owner", 32'(owner), 32'd0);
    check("t6_ok", 32'(mv.move_ok), 32'd0);
    check("t6_ready", 32'(mv.move_ready), 32'd1);
    check("t6_score_x", 32'(score_x), 32'd0);
    check("t6_score_draw", 32'(score_draw), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    play_move(6);
    check("t6_after_ok", 32'(mv.move_ok), 32'd1);
    check("t6_after_marked", 32'(marked), 32'h040);

    // Random play, checked every cycle by the model.
    for (int c = 0; c < 2500; c++) begin
      mv.new_game   = game_done ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
      mv.move_valid = ($urandom_range(0, 2) == 0);
      mv.move_pos   = 4'($urandom_range(0, 10));
      @(negedge clk);
    end
    mv.new_game = 1'b0; mv.move_valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
